// File: rtl/aes_pkg.sv
// Shared definitions for the AES host sequencer.
//   aes_state_e   sequencer state encoding
//   AES_OP_ENC/DEC operation codes carried on aes_ctrl[1:0]
//   AES_CTRL_RUN  bit index of the run/ownership bit in aes_ctrl
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        ERR   = 3'd4
    } aes_state_e;

    localparam logic [1:0] AES_OP_ENC   = 2'b01;
    localparam logic [1:0] AES_OP_DEC   = 2'b10;
    localparam int         AES_CTRL_RUN = 2;

endpackage

// File: rtl/aes_host_fifo.sv
// Two-entry output FIFO for read-back words.
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write one entry (caller guarantees not full)
//   pop           discard head entry (caller guarantees not empty)
//   rdata         head entry
//   count         occupancy, 0..2
module aes_host_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/aes_host_seq.sv
// Host-side sequencer for the AES memory/control port.
// Loads a key + data word stream into AES memory, runs the core, then
// streams the processed data blocks back out with backpressure.
// Optional macro AES_HOST_TIMEOUT_EN adds a completion watchdog in RUN.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   op_in                     operation, latched with the first word of a job
//   s_data/valid/last_in, s_ready_out   input word stream
//   m_data/valid/last_out, m_ready_in   output word stream
//   busy_out, error_out       status (error sticky until next job starts)
//   aes_ctrl_out              {run, op}
//   aes_data_out, aes_mem_we_out, aes_mem_wr_addr_out   memory write port
//   aes_mem_rd_addr_out, aes_data_in                    memory read port
//   aes_complete_in           core done
//
// state | meaning
// IDLE  | waiting for first word (key word 0)
// LOAD  | writing key words 1..3 then data words
// RUN   | core owns memory, waiting for complete
// DRAIN | reading data words back through the output FIFO
// ERR   | bad job length or timeout; flag error, return to IDLE
module aes_host_seq
    import aes_pkg::*;
#(
    parameter logic [9:0]  KEY_BASE       = 10'd0,
    parameter logic [9:0]  DATA_BASE      = 10'd4,
    parameter logic [9:0]  MAX_WORDS      = 10'd512,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] s_data_in,
    input  logic        s_valid_in,
    input  logic        s_last_in,
    output logic        s_ready_out,
    output logic [31:0] m_data_out,
    output logic        m_valid_out,
    output logic        m_last_out,
    input  logic        m_ready_in,
    output logic        busy_out,
    output logic        error_out,
    output logic [2:0]  aes_ctrl_out,
    output logic [31:0] aes_data_out,
    output logic [3:0]  aes_mem_we_out,
    output logic [9:0]  aes_mem_wr_addr_out,
    output logic [9:0]  aes_mem_rd_addr_out,
    input  logic [31:0] aes_data_in,
    input  logic        aes_complete_in
);

    aes_state_e  state, next_state;
    logic [1:0]  op_q;
    logic        error_q;
    logic [1:0]  key_idx;
    logic        key_done;
    logic [9:0]  n_q;
    logic        ovf_q;
    logic        cmpl_q;
    logic        drain_go;
    logic [9:0]  rd_idx;
    logic        rd_pend;
    logic        pend_last;

    logic        accept;
    logic        is_data;
    logic        drop;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [9:0]  n_final;
    logic        ovf_final;
    logic        job_ok;
    logic        cmpl_rise;
    logic        pop;
    logic        issue;
    logic        tmo_hit;
    logic [32:0] fifo_rdata;
    logic [1:0]  fifo_cnt;

    assign s_ready_out = (state == IDLE) || (state == LOAD);
    assign accept      = s_valid_in && s_ready_out;
    assign is_data     = (state == LOAD) && key_done;
    // Data beyond MAX_WORDS is consumed but never written.
    assign drop        = is_data && (n_q == MAX_WORDS);
    assign wr_en       = accept && !drop;
    assign wr_addr     = (state == IDLE) ? KEY_BASE :
                         key_done        ? DATA_BASE + n_q :
                                           KEY_BASE + {8'd0, key_idx};
    assign n_final     = n_q + {9'd0, is_data && !drop};
    assign ovf_final   = ovf_q || drop;
    assign job_ok      = !ovf_final && (n_final >= 10'd4) && (n_final[1:0] == 2'b00);

    assign aes_mem_we_out      = wr_en ? 4'hF : 4'h0;
    assign aes_mem_wr_addr_out = wr_en ? wr_addr : 10'd0;
    assign aes_data_out        = wr_en ? s_data_in : 32'd0;

    assign cmpl_rise   = aes_complete_in && !cmpl_q;
    assign busy_out    = (state != IDLE);
    assign error_out   = error_q;

    assign m_valid_out = (fifo_cnt != 2'd0);
    assign m_data_out  = m_valid_out ? fifo_rdata[31:0] : 32'd0;
    assign m_last_out  = m_valid_out && fifo_rdata[32];
    assign pop         = m_valid_out && m_ready_in;

    // A word popped this cycle frees its slot before the new read lands,
    // which keeps one word per cycle flowing without ever exceeding 2.
    assign issue = (state == DRAIN) && drain_go && (rd_idx != n_q) &&
                   (({1'b0, fifo_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));
    assign aes_mem_rd_addr_out = issue ? DATA_BASE + rd_idx : 10'd0;

    always_comb begin
        aes_ctrl_out = 3'b000;
        if (state == RUN) begin
            aes_ctrl_out[AES_CTRL_RUN] = 1'b1;
            aes_ctrl_out[1:0]          = op_q;
        end
    end

`ifdef AES_HOST_TIMEOUT_EN
    logic [19:0] tmo_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || (state != RUN)) begin
            tmo_cnt <= 20'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
        end
    end

    assign tmo_hit = (state == RUN) && (tmo_cnt == TIMEOUT_CYCLES - 20'd1);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = s_last_in ? ERR : LOAD;
            LOAD:    if (accept && s_last_in) next_state = job_ok ? RUN : ERR;
            RUN: begin
                if (cmpl_rise)    next_state = DRAIN;
                else if (tmo_hit) next_state = ERR;
            end
            DRAIN:   if (pop && m_last_out) next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            op_q      <= 2'b00;
            error_q   <= 1'b0;
            key_idx   <= 2'd0;
            key_done  <= 1'b0;
            n_q       <= 10'd0;
            ovf_q     <= 1'b0;
            cmpl_q    <= 1'b0;
            drain_go  <= 1'b0;
            rd_idx    <= 10'd0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state  <= next_state;
            cmpl_q <= aes_complete_in;
            if (accept) begin
                if (state == IDLE) begin
                    op_q     <= op_in;
                    key_idx  <= 2'd1;
                    key_done <= 1'b0;
                    n_q      <= 10'd0;
                    ovf_q    <= 1'b0;
                    error_q  <= 1'b0;
                end else if (!key_done) begin
                    key_idx  <= key_idx + 2'd1;
                    key_done <= (key_idx == 2'd3);
                end else begin
                    n_q   <= n_final;
                    ovf_q <= ovf_final;
                end
            end
            if ((next_state == ERR) && (state != ERR)) begin
                error_q <= 1'b1;
            end
            // One idle cycle after run drops before the first read.
            drain_go  <= (state == DRAIN);
            rd_idx    <= (state == DRAIN) ? rd_idx + {9'd0, issue} : 10'd0;
            rd_pend   <= issue;
            pend_last <= issue && (rd_idx == n_q - 10'd1);
        end
    end

    aes_host_fifo #(.W(33)) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rd_pend),
        .wdata ({pend_last, aes_data_in}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_aes_host_seq.sv
// Directed bench for aes_host_seq. Models AES memory (read data is the
// bitwise inverse of the stored word, standing in for the core) and logs
// every memory write and every output handshake.
module tb_aes_host_seq;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [1:0]  op_in;
    logic [31:0] s_data_in;
    logic        s_valid_in;
    logic        s_last_in;
    logic        s_ready_out;
    logic [31:0] m_data_out;
    logic        m_valid_out;
    logic        m_last_out;
    logic        m_ready_in;
    logic        busy_out;
    logic        error_out;
    logic [2:0]  aes_ctrl_out;
    logic [31:0] aes_data_out;
    logic [3:0]  aes_mem_we_out;
    logic [9:0]  aes_mem_wr_addr_out;
    logic [9:0]  aes_mem_rd_addr_out;
    logic [31:0] aes_data_in = 32'd0;
    logic        aes_complete_in;

    always #5 clk = ~clk;

    aes_host_seq #(
        .KEY_BASE       (10'd0),
        .DATA_BASE      (10'd4),
        .MAX_WORDS      (10'd8),
        .TIMEOUT_CYCLES (20'd100)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst_in),
        .op_in               (op_in),
        .s_data_in           (s_data_in),
        .s_valid_in          (s_valid_in),
        .s_last_in           (s_last_in),
        .s_ready_out         (s_ready_out),
        .m_data_out          (m_data_out),
        .m_valid_out         (m_valid_out),
        .m_last_out          (m_last_out),
        .m_ready_in          (m_ready_in),
        .busy_out            (busy_out),
        .error_out           (error_out),
        .aes_ctrl_out        (aes_ctrl_out),
        .aes_data_out        (aes_data_out),
        .aes_mem_we_out      (aes_mem_we_out),
        .aes_mem_wr_addr_out (aes_mem_wr_addr_out),
        .aes_mem_rd_addr_out (aes_mem_rd_addr_out),
        .aes_data_in         (aes_data_in),
        .aes_complete_in     (aes_complete_in)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    int          wr_cnt   = 0;
    int          out_cnt  = 0;
    int          run_cnt  = 0;
    int          stab_err = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data = 32'd0;
    logic        hold_last = 1'b0;
    logic [9:0]  wlog_addr [0:255];
    logic [31:0] wlog_data [0:255];
    logic [3:0]  wlog_we   [0:255];
    logic [31:0] olog_data [0:255];
    logic        olog_last [0:255];

    always @(posedge clk) begin
        if (aes_mem_we_out != 4'h0) begin
            if (aes_mem_we_out == 4'hF) mem[aes_mem_wr_addr_out] <= aes_data_out;
            wlog_addr[wr_cnt[7:0]] <= aes_mem_wr_addr_out;
            wlog_data[wr_cnt[7:0]] <= aes_data_out;
            wlog_we[wr_cnt[7:0]]   <= aes_mem_we_out;
            wr_cnt <= wr_cnt + 1;
        end
        aes_data_in <= ~mem[aes_mem_rd_addr_out];
        if (aes_ctrl_out[2]) run_cnt <= run_cnt + 1;
        if (m_valid_out && m_ready_in) begin
            olog_data[out_cnt[7:0]] <= m_data_out;
            olog_last[out_cnt[7:0]] <= m_last_out;
            out_cnt <= out_cnt + 1;
        end
        if (!rst_in && hold_pend &&
            (m_valid_out !== 1'b1 || m_data_out !== hold_data || m_last_out !== hold_last))
            stab_err <= stab_err + 1;
        hold_pend <= !rst_in && m_valid_out && !m_ready_in;
        hold_data <= m_data_out;
        hold_last <= m_last_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word i of a job carries seed+i; op_in is wrong after word 0 so a late latch shows.
    task automatic send_job(input int total, input logic [1:0] op, input logic [31:0] seed);
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i == 1) chk("err_clr", {31'd0, error_out}, 32'd0);
            op_in      = (i == 0) ? op : ~op;
            s_valid_in = 1'b1;
            s_data_in  = seed + 32'(i);
            s_last_in  = (i == total - 1);
        end
        @(negedge clk);
        s_valid_in = 1'b0;
        s_last_in  = 1'b0;
        s_data_in  = 32'd0;
    endtask

    task automatic pulse_complete(input int delay);
        repeat (delay) @(negedge clk);
        aes_complete_in = 1'b1;
        @(negedge clk);
        aes_complete_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        int c = 0;
        while (busy_out && c < budget) begin
            @(negedge clk);
            if (toggle) m_ready_in = ~m_ready_in;
            c++;
        end
        m_ready_in = 1'b1;
        chk("idle_wait", {31'd0, c < budget}, 32'd1);
    endtask

    task automatic check_writes(input string tag, input int base, input int n, input logic [31:0] seed);
        chk({tag, "_wr_cnt"}, wr_cnt - base, n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr_addr"}, {22'd0, wlog_addr[8'(base + i)]}, 32'(i));
            chk({tag, "_wr_data"}, wlog_data[8'(base + i)], seed + 32'(i));
            chk({tag, "_wr_we"}, {28'd0, wlog_we[8'(base + i)]}, 32'hF);
        end
    endtask

    task automatic check_out(input string tag, input int base, input int n, input logic [31:0] seed);
        chk({tag, "_out_cnt"}, out_cnt - base, n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_out_data"}, olog_data[8'(base + k)], ~(seed + 32'(4 + k)));
            chk({tag, "_out_last"}, {31'd0, olog_last[8'(base + k)]}, (k == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int base_w, base_o, base_r, c;
        rst_in = 1'b1; op_in = 2'b00; s_data_in = 32'd0; s_valid_in = 1'b0;
        s_last_in = 1'b0; m_ready_in = 1'b1; aes_complete_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", {27'd0, s_ready_out, m_valid_out, m_last_out, busy_out, error_out}, 32'h10);
        chk("rst_ctrl_we", {25'd0, aes_ctrl_out, aes_mem_we_out}, 32'd0);
        chk("rst_addrs", {12'd0, aes_mem_wr_addr_out, aes_mem_rd_addr_out}, 32'd0);
        chk("rst_data", aes_data_out | m_data_out, 32'd0);
        rst_in = 1'b0;

        // Encrypt, 4 key + 4 data, exact completion/read timing
        base_w = wr_cnt; base_o = out_cnt;
        send_job(8, AES_OP_ENC, 32'hA000_0000);
        chk("t1_run", {29'd0, aes_ctrl_out}, 32'h5);
        chk("t1_s_ready", {31'd0, s_ready_out}, 32'd0);
        pulse_complete(19);
        chk("t1_run_drop", {29'd0, aes_ctrl_out}, 32'd0);
        chk("t1_no_rd_yet", {22'd0, aes_mem_rd_addr_out}, 32'd0);
        @(negedge clk);
        chk("t1_rd_first", {22'd0, aes_mem_rd_addr_out}, 32'd4);
        @(negedge clk);
        chk("t1_valid_early", {31'd0, m_valid_out}, 32'd0);
        @(negedge clk);
        chk("t1_valid_first", {31'd0, m_valid_out}, 32'd1);
        chk("t1_data_first", m_data_out, ~32'hA000_0004);
        wait_idle(50, 1'b0);
        check_writes("t1", base_w, 8, 32'hA000_0000);
        check_out("t1", base_o, 4, 32'hA000_0000);
        chk("t1_error", {31'd0, error_out}, 32'd0);

        // Decrypt with m_ready toggling every cycle
        base_o = out_cnt;
        send_job(8, AES_OP_DEC, 32'hB000_0000);
        chk("t2_run", {29'd0, aes_ctrl_out}, 32'h6);
        pulse_complete(20);
        wait_idle(60, 1'b1);
        check_out("t2", base_o, 4, 32'hB000_0000);
        chk("t2_stable", stab_err, 32'd0);

        // n=2: length error, nothing run
        base_w = wr_cnt; base_r = run_cnt;
        send_job(6, AES_OP_ENC, 32'hC000_0000);
        chk("t3_err_state", {29'd0, error_out, busy_out, s_ready_out}, 32'h6);
        @(negedge clk);
        chk("t3_back_idle", {29'd0, error_out, busy_out, s_ready_out}, 32'h5);
        chk("t3_no_run", run_cnt - base_r, 32'd0);
        chk("t3_wr_cnt", wr_cnt - base_w, 32'd6);

        // 12 data words against MAX_WORDS=8: writes stop at address 11
        base_w = wr_cnt; base_r = run_cnt;
        send_job(16, AES_OP_ENC, 32'hD000_0000);
        chk("t4_error", {31'd0, error_out}, 32'd1);
        check_writes("t4", base_w, 12, 32'hD000_0000);
        chk("t4_no_run", run_cnt - base_r, 32'd0);
        @(negedge clk);
        chk("t4_idle", {31'd0, busy_out}, 32'd0);

        // Reset in the middle of DRAIN after two outputs
        base_o = out_cnt;
        send_job(12, AES_OP_ENC, 32'hE000_0000);
        pulse_complete(20);
        c = 0;
        while ((out_cnt - base_o) < 2 && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("t5_two_out", out_cnt - base_o, 32'd2);
        rst_in = 1'b1;
        m_ready_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b0;
        chk("t5_rst_status", {28'd0, s_ready_out, m_valid_out, busy_out, error_out}, 32'h8);
        chk("t5_rst_ctrl", {29'd0, aes_ctrl_out}, 32'd0);
        m_ready_in = 1'b1;
        @(negedge clk);
        chk("t5_out_kept", out_cnt - base_o, 32'd2);
        chk("t5_out0", olog_data[8'(base_o)], ~32'hE000_0004);

        // Normal job after the reset
        base_o = out_cnt;
        send_job(8, AES_OP_ENC, 32'hF000_0000);
        pulse_complete(20);
        wait_idle(50, 1'b0);
        check_out("t6", base_o, 4, 32'hF000_0000);
        chk("t6_error", {31'd0, error_out}, 32'd0);

`ifdef AES_HOST_TIMEOUT_EN
        // No completion: watchdog drops run after 100 RUN cycles
        send_job(8, AES_OP_ENC, 32'h1234_0000);
        c = 0;
        while (aes_ctrl_out[2] && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("t7_run_cycles", c, 32'd100);
        chk("t7_error", {31'd0, error_out}, 32'd1);
        @(negedge clk);
        chk("t7_idle", {31'd0, busy_out}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
